mem_writeback_stage: RTL
========================

# mem_writeback_stage

Back half of the 16-bit MIPS pipeline: the EX/MEM register, data-memory access, the MEM/WB register and write-back mux. It drives the ports that Fetch and Decode expect "from next stages": `PC_Src`/`branch_target` into Fetch and `In_RegWrite`/`write_register`/`write_Data` into Decode. It also resolves taken branches, squashes the wrong-path instruction and counts retired instructions.

## Interface
Parameters:
- `DATA_W`, 16: datapath and address width.
- `REG_AW`, 3: register-number width.
- `DMEM_DEPTH`, 256: data-memory depth in 16-bit words; power of two.

Ports:
- `clk`  in  1: the only clock; all state updates on its rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `ex_valid`  in  1: EX stage holds a real instruction.
- `ex_alu_result`  in  DATA_W: ALU result or byte address.
- `ex_zero`  in  1: ALU zero flag.
- `ex_branch_target`  in  DATA_W: computed branch target.
- `ex_store_data`  in  DATA_W: rt value for stores.
- `ex_write_register`  in  REG_AW: destination register after RegDst mux.
- `ex_RegWrite`, `ex_MemtoReg`, `ex_MemRead`, `ex_MemWrite`, `ex_Branch`  in  1 each: control bits from Decode.
- `PC_Src`  out  1: to Fetch; take the branch.
- `branch_target`  out  DATA_W: to Fetch.
- `flush`  out  1: to IF_ID and ID_EX; squash younger instructions.
- `In_RegWrite`  out  1: to Decode register-file write enable.
- `write_register`  out  REG_AW: to Decode.
- `write_Data`  out  DATA_W: to Decode.
- `retire_count`  out  DATA_W: count of valid instructions that left MEM/WB.

## Operation
- EX/MEM register:
  - Captures all `ex_*` fields every cycle.
  - Captured valid = `ex_valid & ~PC_Src`. The instruction in EX while a branch resolves is wrong-path.
- Branch resolution is combinational from EX/MEM:
  - `PC_Src = mem_valid & mem_Branch & mem_zero`.
  - `branch_target = mem_branch_target`.
  - `flush = PC_Src`.
- Data memory:
  - Word index is `mem_alu_result[log2(DMEM_DEPTH):1]`. Bit 0 is ignored; upper bits wrap modulo depth.
  - Write: on the clock edge when `mem_valid & mem_MemWrite`.
  - Read: asynchronous. The result is captured into MEM/WB when `mem_MemRead`; otherwise read data is captured as 0.
- MEM/WB register captures valid, RegWrite, MemtoReg, write register, ALU result and read data.
- Write-back:
  - `write_Data = wb_MemtoReg ? wb_read_data : wb_alu_result`.
  - `In_RegWrite = wb_valid & wb_RegWrite & (wb_write_register != 0)`. r0 is never written.
- `retire_count` increments by 1 on each edge where `wb_valid` is high. It wraps from 0xFFFF to 0.
- Reset:
  - Clears both valid bits, all pipeline fields and `retire_count`.
  - Every output is 0 during and after reset until new instructions arrive.
  - Memory contents are not reset.
  - A store sitting in EX/MEM on the reset edge is not performed; reset has priority over the write.

## Timing
- An instruction presented on `ex_*` at edge N:
  - is in EX/MEM during cycle N..N+1;
  - is in MEM/WB during N+1..N+2;
  - its register write lands in Decode at edge N+2.
- Branch: `PC_Src` and `flush` are high for exactly the one cycle the branch occupies EX/MEM. Fetch redirects at the following edge.
- Store followed by a load to the same address in the next cycle: the load sees the new data, because the write occurs at the edge that moves the load into EX/MEM.
- Two consecutive taken branches: the second is squashed by the first and does not assert `PC_Src`.
- Squashed instructions:
  - never write memory or registers;
  - never assert `PC_Src`;
  - never count toward `retire_count`.

## Structure
- `mips_pkg` holds the width constants (DATA_W, REG_AW) and a packed struct for the control bundle (RegWrite, MemtoReg, MemRead, MemWrite, Branch). Decode and the pipeline registers share this struct.
- One sub-module, `data_memory`: a single-port RAM with synchronous write and asynchronous read, parameterised by DATA_W and DMEM_DEPTH.

## Test plan
- ALU op: `ex_alu_result=0x1234`, RegWrite=1, reg=3, MemtoReg=0 at edge 0 -> `In_RegWrite=1`, `write_register=3`, `write_Data=0x1234` in cycle 1..2; `retire_count=1` after edge 2.
- Store then load: store 0xBEEF at address 0x0010, then a load from 0x0011 in the next cycle with MemtoReg=1, reg=5 -> `write_Data=0xBEEF` (bit 0 ignored); the register write fires for the load only.
- Taken branch: Branch=1, zero=1, target=0x0040, followed by an ALU op with RegWrite=1 -> `PC_Src=flush=1` for one cycle with `branch_target=0x0040`; the follower never raises `In_RegWrite`; `retire_count` rises by 1.
- Untaken branch (zero=0) -> `PC_Src` stays 0; the following instruction retires normally.
- r0 write: RegWrite=1, reg=0 -> `In_RegWrite` stays 0.
- Reset mid-stream: `rst` on the edge where a store to 0x0020 sits in EX/MEM -> memory[0x10] is unchanged, all outputs are 0 and `retire_count=0` next cycle.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared widths and the control bundle carried from Decode through the
// EX/MEM pipeline register.
package mips_pkg;

    localparam int DATA_W = 16;
    localparam int REG_AW = 3;

    typedef struct packed {
        logic RegWrite;
        logic MemtoReg;
        logic MemRead;
        logic MemWrite;
        logic Branch;
    } ctrl_t;

endpackage

// File: rtl/data_memory.sv
// Single-port data RAM: write on the rising edge, asynchronous read.
// Contents are deliberately not reset.
module data_memory #(
    parameter int DATA_W     = 16,
    parameter int DMEM_DEPTH = 256,
    parameter int AW         = $clog2(DMEM_DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [AW-1:0]     addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DMEM_DEPTH];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/mem_writeback_stage.sv
// Back half of the 16-bit MIPS pipeline: EX/MEM register, data memory,
// MEM/WB register, write-back mux, branch resolution and retire counter.
module mem_writeback_stage #(
    parameter int DATA_W     = 16,
    parameter int REG_AW     = 3,
    parameter int DMEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ex_valid,
    input  logic [DATA_W-1:0] ex_alu_result,
    input  logic              ex_zero,
    input  logic [DATA_W-1:0] ex_branch_target,
    input  logic [DATA_W-1:0] ex_store_data,
    input  logic [REG_AW-1:0] ex_write_register,
    input  logic              ex_RegWrite,
    input  logic              ex_MemtoReg,
    input  logic              ex_MemRead,
    input  logic              ex_MemWrite,
    input  logic              ex_Branch,
    output logic              PC_Src,
    output logic [DATA_W-1:0] branch_target,
    output logic              flush,
    output logic              In_RegWrite,
    output logic [REG_AW-1:0] write_register,
    output logic [DATA_W-1:0] write_Data,
    output logic [DATA_W-1:0] retire_count
);
    import mips_pkg::*;

    localparam int AW = $clog2(DMEM_DEPTH);

    ctrl_t ex_ctrl;

    // EX/MEM
    logic              mem_valid_q,  mem_valid_d;
    ctrl_t             mem_ctrl_q,   mem_ctrl_d;
    logic [DATA_W-1:0] mem_alu_q,    mem_alu_d;
    logic              mem_zero_q,   mem_zero_d;
    logic [DATA_W-1:0] mem_target_q, mem_target_d;
    logic [DATA_W-1:0] mem_store_q,  mem_store_d;
    logic [REG_AW-1:0] mem_wreg_q,   mem_wreg_d;

    // MEM/WB
    logic              wb_valid_q,     wb_valid_d;
    logic              wb_reg_write_q, wb_reg_write_d;
    logic              wb_mem_to_reg_q, wb_mem_to_reg_d;
    logic [REG_AW-1:0] wb_wreg_q,      wb_wreg_d;
    logic [DATA_W-1:0] wb_alu_q,       wb_alu_d;
    logic [DATA_W-1:0] wb_rdata_q,     wb_rdata_d;

    logic [DATA_W-1:0] retire_q, retire_d;

    logic              dmem_we;
    logic [DATA_W-1:0] dmem_rdata;

    assign ex_ctrl = '{RegWrite: ex_RegWrite, MemtoReg: ex_MemtoReg,
                       MemRead:  ex_MemRead,  MemWrite: ex_MemWrite,
                       Branch:   ex_Branch};

    assign PC_Src        = mem_valid_q & mem_ctrl_q.Branch & mem_zero_q;
    assign branch_target = mem_target_q;
    assign flush         = PC_Src;

    // Reset outranks a store sitting in EX/MEM on the reset edge.
    assign dmem_we = mem_valid_q & mem_ctrl_q.MemWrite & ~rst;

    data_memory #(
        .DATA_W    (DATA_W),
        .DMEM_DEPTH(DMEM_DEPTH),
        .AW        (AW)
    ) u_dmem (
        .clk    (clk),
        .we_i   (dmem_we),
        .addr_i (mem_alu_q[AW:1]),
        .wdata_i(mem_store_q),
        .rdata_o(dmem_rdata)
    );

    always_comb begin
        // The instruction behind a resolving taken branch is wrong-path.
        mem_valid_d     = ex_valid & ~PC_Src;
        mem_ctrl_d      = ex_ctrl;
        mem_alu_d       = ex_alu_result;
        mem_zero_d      = ex_zero;
        mem_target_d    = ex_branch_target;
        mem_store_d     = ex_store_data;
        mem_wreg_d      = ex_write_register;

        wb_valid_d      = mem_valid_q;
        wb_reg_write_d  = mem_ctrl_q.RegWrite;
        wb_mem_to_reg_d = mem_ctrl_q.MemtoReg;
        wb_wreg_d       = mem_wreg_q;
        wb_alu_d        = mem_alu_q;
        wb_rdata_d      = mem_ctrl_q.MemRead ? dmem_rdata : '0;

        retire_d        = retire_q + DATA_W'(wb_valid_q);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mem_valid_q     <= 1'b0;
            mem_ctrl_q      <= '0;
            mem_alu_q       <= '0;
            mem_zero_q      <= 1'b0;
            mem_target_q    <= '0;
            mem_store_q     <= '0;
            mem_wreg_q      <= '0;
            wb_valid_q      <= 1'b0;
            wb_reg_write_q  <= 1'b0;
            wb_mem_to_reg_q <= 1'b0;
            wb_wreg_q       <= '0;
            wb_alu_q        <= '0;
            wb_rdata_q      <= '0;
            retire_q        <= '0;
        end else begin
            mem_valid_q     <= mem_valid_d;
            mem_ctrl_q      <= mem_ctrl_d;
            mem_alu_q       <= mem_alu_d;
            mem_zero_q      <= mem_zero_d;
            mem_target_q    <= mem_target_d;
            mem_store_q     <= mem_store_d;
            mem_wreg_q      <= mem_wreg_d;
            wb_valid_q      <= wb_valid_d;
            wb_reg_write_q  <= wb_reg_write_d;
            wb_mem_to_reg_q <= wb_mem_to_reg_d;
            wb_wreg_q       <= wb_wreg_d;
            wb_alu_q        <= wb_alu_d;
            wb_rdata_q      <= wb_rdata_d;
            retire_q        <= retire_d;
        end
    end

    assign write_Data     = wb_mem_to_reg_q ? wb_rdata_q : wb_alu_q;
    assign In_RegWrite    = wb_valid_q & wb_reg_write_q & (wb_wreg_q != '0);
    assign write_register = wb_wreg_q;
    assign retire_count   = retire_q;

endmodule
